// File: rtl/layer2_weight_loader.sv
// Run-time loader for Layer 2 weights and biases: packs a serial word stream into
// rows and drives the Layer 2 controller storage write port while holding off inference.
module layer2_weight_loader #(
    parameter int unsigned NODE_COUNT  = 100,
    parameter int unsigned INDEX_WIDTH = 7,
    parameter int unsigned WORD_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     loadStart,
    input  logic                     loadAbort,
    input  logic [WORD_WIDTH-1:0]    wordIn,
    input  logic                     wordValid,
    output logic                     wordReady,
    input  logic                     layerBusy,
    output logic                     inferenceHold,
    output logic                     weightWriteEnable,
    output logic                     biasWriteEnable,
    output logic [INDEX_WIDTH-1:0]   WriteAddressSelect,
    output logic [10*WORD_WIDTH-1:0] writeIn,
    output logic                     loadDone
);

    localparam int unsigned LANES      = 10;
    localparam int unsigned LANE_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE, WAIT, COLLECT, WRITE, BCOLLECT, BWRITE, DONE
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] row;
    logic [LANE_WIDTH-1:0]  lane;
    logic                   lastLane;

    // Ready depends on state alone so the host never sees a combinational loop through wordValid.
    assign wordReady = (state == COLLECT) || (state == BCOLLECT);
    assign lastLane  = (lane == LANE_WIDTH'(LANES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            row                <= '0;
            lane               <= '0;
            inferenceHold      <= 1'b0;
            weightWriteEnable  <= 1'b0;
            biasWriteEnable    <= 1'b0;
            WriteAddressSelect <= '0;
            writeIn            <= '0;
            loadDone           <= 1'b0;
        end else begin
            weightWriteEnable <= 1'b0;
            biasWriteEnable   <= 1'b0;
            loadDone          <= 1'b0;
            if (loadAbort && (state != IDLE)) begin
                // Abandon the load; the partial row is discarded and no strobe is issued.
                state              <= IDLE;
                row                <= '0;
                lane               <= '0;
                inferenceHold      <= 1'b0;
                WriteAddressSelect <= '0;
                writeIn            <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (loadStart) begin
                            state         <= WAIT;
                            inferenceHold <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (!layerBusy) begin
                            state <= COLLECT;
                            row   <= '0;
                            lane  <= '0;
                        end
                    end
                    COLLECT, BCOLLECT: begin
                        if (wordValid) begin
                            for (int k = 0; k < LANES; k++) begin
                                if (lane == LANE_WIDTH'(k)) begin
                                    writeIn[k*WORD_WIDTH +: WORD_WIDTH] <= wordIn;
                                end
                            end
                            if (lastLane) begin
                                lane <= '0;
                                if (state == COLLECT) begin
                                    state              <= WRITE;
                                    weightWriteEnable  <= 1'b1;
                                    WriteAddressSelect <= row;
                                end else begin
                                    state              <= BWRITE;
                                    biasWriteEnable    <= 1'b1;
                                    WriteAddressSelect <= '0;
                                end
                            end else begin
                                lane <= lane + LANE_WIDTH'(1);
                            end
                        end
                    end
                    WRITE: begin
                        if (row == INDEX_WIDTH'(NODE_COUNT - 1)) begin
                            state <= BCOLLECT;
                        end else begin
                            row   <= row + INDEX_WIDTH'(1);
                            state <= COLLECT;
                        end
                    end
                    BWRITE: begin
                        state    <= DONE;
                        loadDone <= 1'b1;
                    end
                    DONE: begin
                        state         <= IDLE;
                        inferenceHold <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer2_weight_loader.sv
// Directed bench for layer2_weight_loader with NODE_COUNT=4: a negedge monitor logs every
// strobe, and the main sequence compares logged rows against hand-computed packed rows.
module tb_layer2_weight_loader;

    localparam int unsigned W   = 8;
    localparam int unsigned IW  = 7;
    localparam int unsigned RW  = 10 * W;

    logic          clk;
    logic          reset;
    logic          loadStart;
    logic          loadAbort;
    logic [W-1:0]  wordIn;
    logic          wordValid;
    logic          wordReady;
    logic          layerBusy;
    logic          inferenceHold;
    logic          weightWriteEnable;
    logic          biasWriteEnable;
    logic [IW-1:0] WriteAddressSelect;
    logic [RW-1:0] writeIn;
    logic          loadDone;

    layer2_weight_loader #(.NODE_COUNT(4), .INDEX_WIDTH(IW), .WORD_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .loadStart(loadStart), .loadAbort(loadAbort),
        .wordIn(wordIn), .wordValid(wordValid), .wordReady(wordReady),
        .layerBusy(layerBusy), .inferenceHold(inferenceHold),
        .weightWriteEnable(weightWriteEnable), .biasWriteEnable(biasWriteEnable),
        .WriteAddressSelect(WriteAddressSelect), .writeIn(writeIn), .loadDone(loadDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Strobe log written only by the monitor.
    logic [IW-1:0] wAddr [0:63];
    logic [RW-1:0] wData [0:63];
    logic [IW-1:0] bAddr [0:15];
    logic [RW-1:0] bData [0:15];
    int wCount = 0, bCount = 0, doneCount = 0, doneCycle = 0;
    int overlapCount = 0, doubleCount = 0;
    logic prevW = 1'b0, prevB = 1'b0;

    always @(negedge clk) begin
        if (weightWriteEnable) begin
            wAddr[wCount] <= WriteAddressSelect;
            wData[wCount] <= writeIn;
            wCount <= wCount + 1;
        end
        if (biasWriteEnable) begin
            bAddr[bCount] <= WriteAddressSelect;
            bData[bCount] <= writeIn;
            bCount <= bCount + 1;
        end
        if (weightWriteEnable && biasWriteEnable) overlapCount <= overlapCount + 1;
        if ((weightWriteEnable && prevW) || (biasWriteEnable && prevB)) doubleCount <= doubleCount + 1;
        if (loadDone) begin
            doneCount <= doneCount + 1;
            doneCycle <= cycleCnt;
        end
        prevW <= weightWriteEnable;
        prevB <= biasWriteEnable;
    end

    int nChecks = 0, nPassed = 0;
    int nextIdx = 0;
    int startCycle = 0;
    logic toggleMode = 1'b0;

    task automatic check(input string tag, input logic [RW-1:0] observed, input logic [RW-1:0] expected);
        nChecks++;
        if (observed === expected) nPassed++;
        else $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [RW-1:0] expRow(input int base);
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < 10; k++) v[k*W +: W] = W'(base + k);
        return v;
    endfunction

    // One clock: count the transfer seen at this edge, then present the next word.
    task automatic tick();
        logic xfer;
        xfer = wordValid && wordReady;
        @(posedge clk);
        if (xfer) nextIdx++;
        #1;
        wordIn = W'(nextIdx);
        if (toggleMode) wordValid = ~wordValid;
    endtask

    task automatic restartStream();
        nextIdx = 0;
        wordIn  = '0;
    endtask

    task automatic pulseStart();
        loadStart  = 1'b1;
        startCycle = cycleCnt;
        tick();
        loadStart  = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int base;
        base = doneCount;
        for (int i = 0; i < budget && doneCount == base; i++) tick();
        check("doneSeen", RW'(doneCount - base), RW'(1));
    endtask

    task automatic tickUntilIdx(input int target);
        for (int i = 0; i < 200 && nextIdx != target; i++) tick();
        check("reachIdx", RW'(nextIdx), RW'(target));
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, ".wordReady"}, RW'(wordReady), RW'(0));
        check({tag, ".hold"}, RW'(inferenceHold), RW'(0));
        check({tag, ".wEn"}, RW'(weightWriteEnable), RW'(0));
        check({tag, ".bEn"}, RW'(biasWriteEnable), RW'(0));
        check({tag, ".addr"}, RW'(WriteAddressSelect), RW'(0));
        check({tag, ".writeIn"}, writeIn, RW'(0));
        check({tag, ".done"}, RW'(loadDone), RW'(0));
    endtask

    task automatic checkFullLog(input string tag, input int wBase, input int bBase);
        check({tag, ".rows"}, RW'(wCount - wBase), RW'(4));
        for (int r = 0; r < 4; r++) begin
            check({tag, ".addr"}, RW'(wAddr[wBase + r]), RW'(r));
            check({tag, ".row"}, wData[wBase + r], expRow(10 * r));
        end
        check({tag, ".biasCnt"}, RW'(bCount - bBase), RW'(1));
        check({tag, ".biasAddr"}, RW'(bAddr[bBase]), RW'(0));
        check({tag, ".biasRow"}, bData[bBase], expRow(40));
    endtask

    initial begin
        int wBase, bBase, dBase, bad;
        reset = 1'b1; loadStart = 1'b0; loadAbort = 1'b0;
        wordIn = '0; wordValid = 1'b1; layerBusy = 1'b0;
        tick(); tick();
        checkZeroOutputs("reset");
        reset = 1'b0;
        tick();

        // Reset in the middle of a row.
        restartStream();
        pulseStart();
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("midCollect.words", RW'(nextIdx), RW'(5));
        reset = 1'b1;
        #1;
        checkZeroOutputs("midReset");
        reset = 1'b0;
        restartStream();
        tick();

        // Full load, wordValid held high; also proves restart from row 0 lane 0.
        wBase = wCount; bBase = bCount;
        pulseStart();
        waitDone(200);
        checkFullLog("full", wBase, bBase);
        check("full.latency", RW'(doneCycle - startCycle), RW'(57));
        check("full.holdAfter", RW'(inferenceHold), RW'(0));

        // layerBusy holds the loader in WAIT.
        restartStream();
        layerBusy = 1'b1;
        bBase = bCount;
        pulseStart();
        bad = 0;
        for (int i = 1; i < 20; i++) begin
            if (wordReady !== 1'b0 || inferenceHold !== 1'b1) bad++;
            tick();
        end
        if (wordReady !== 1'b0 || inferenceHold !== 1'b1) bad++;
        check("busy.waitCycles", RW'(bad), RW'(0));
        layerBusy = 1'b0;
        tick();
        check("busy.readyAfter", RW'(wordReady), RW'(1));
        check("busy.noEarlyXfer", RW'(nextIdx), RW'(0));
        tick();
        check("busy.firstXfer", RW'(nextIdx), RW'(1));
        waitDone(200);
        check("busy.biasRow", bData[bBase], expRow(40));

        // wordValid toggling every other cycle.
        restartStream();
        wBase = wCount; bBase = bCount;
        toggleMode = 1'b1;
        pulseStart();
        waitDone(400);
        toggleMode = 1'b0;
        wordValid = 1'b1;
        checkFullLog("toggle", wBase, bBase);
        check("strobe.double", RW'(doubleCount), RW'(0));
        check("strobe.overlap", RW'(overlapCount), RW'(0));

        // Abort coinciding with the last word of row 2.
        restartStream();
        wBase = wCount; dBase = doneCount;
        pulseStart();
        tickUntilIdx(29);
        loadAbort = 1'b1;
        tick();
        loadAbort = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("abort.rows", RW'(wCount - wBase), RW'(2));
        check("abort.row0", wData[wBase], expRow(0));
        check("abort.row1", wData[wBase + 1], expRow(10));
        check("abort.noDone", RW'(doneCount - dBase), RW'(0));
        check("abort.ready", RW'(wordReady), RW'(0));
        check("abort.hold", RW'(inferenceHold), RW'(0));

        // Abort is ignored in IDLE; a simultaneous loadStart still starts a load.
        layerBusy = 1'b1;
        loadAbort = 1'b1;
        pulseStart();
        loadAbort = 1'b0;
        check("idleAbort.hold", RW'(inferenceHold), RW'(1));
        loadAbort = 1'b1;
        tick();
        loadAbort = 1'b0;
        layerBusy = 1'b0;
        check("waitAbort.hold", RW'(inferenceHold), RW'(0));

        // loadStart during COLLECT is ignored; a stall keeps the lane.
        restartStream();
        wBase = wCount; bBase = bCount;
        pulseStart();
        tickUntilIdx(3);
        wordValid = 1'b0;
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("midStart.ready", RW'(wordReady), RW'(1));
        check("midStart.hold", RW'(inferenceHold), RW'(1));
        check("midStart.stallIdx", RW'(nextIdx), RW'(3));
        wordValid = 1'b1;
        waitDone(200);
        checkFullLog("midStart", wBase, bBase);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
